// File: rtl/param_dp_ram.sv
// param_dp_ram: dual-port RAM cleared after reset; ports wr_en/wr_add/data_in write, rd_en/rd_add -> data_out/rd_valid, init_busy during clear, collision on same-address read+write
module param_dp_ram #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 3,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_add,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              collision
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic rd_valid_q, rd_valid_d, collision_q, collision_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic ready, we, rd_fire;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    ready = state_q == READY;
    we = !rst && (ready ? wr_en : 1'b1);
    waddr = ready ? wr_add : clr_cnt_q;
    wdata = ready ? data_in : '0;
    rd_fire = ready && rd_en;
    collision_d = rd_fire && wr_en && rd_add == wr_add;
    rd_valid_d = rd_fire;
    data_out_d = !rd_fire ? data_out_q : (collision_d && RDW_MODE == 0) ? data_in : mem_q[rd_add];
    state_d = (ready || clr_cnt_q == {ADDR_W{1'b1}}) ? READY : CLEAR;
    clr_cnt_d = ready ? '0 : clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_cnt_q <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      collision_q <= collision_d;
    end
  end
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign collision = collision_q;
  assign init_busy = state_q == CLEAR;
endmodule

// File: tb/tb_param_dp_ram.sv
// tb_param_dp_ram: directed self-checking bench for both read-during-write policies
module tb_param_dp_ram;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0] wr_add = '0, rd_add = '0, data_in = '0;
  logic [2:0] dout0, dout1;
  logic rv0, rv1, busy0, busy1, coll0, coll1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  param_dp_ram #(.DATA_W(3), .ADDR_W(3), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_add(wr_add), .data_in(data_in),
    .rd_en(rd_en), .rd_add(rd_add), .data_out(dout0), .rd_valid(rv0),
    .init_busy(busy0), .collision(coll0));
  param_dp_ram #(.DATA_W(3), .ADDR_W(3), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_add(wr_add), .data_in(data_in),
    .rd_en(rd_en), .rd_add(rd_add), .data_out(dout1), .rd_valid(rv1),
    .init_busy(busy1), .collision(coll1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy0", {31'b0, busy0}, 1);
    chk("rst_busy1", {31'b0, busy1}, 1);
    chk("rst_dout0", {29'b0, dout0}, 0);
    chk("rst_rv0", {31'b0, rv0}, 0);
    chk("rst_coll0", {31'b0, coll0}, 0);
    chk("rst_dout1", {29'b0, dout1}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("clr_busy", {31'b0, busy0}, 1);
      wr_en = (i == 2);
      wr_add = 3'd0;
      data_in = 3'b111;
      rd_en = 1'b1;
      rd_add = 3'd0;
      tick();
      chk("clr_rv", {31'b0, rv0}, 0);
      chk("clr_coll", {31'b0, coll0}, 0);
    end
    wr_en = 1'b0;
    chk("clr_done0", {31'b0, busy0}, 0);
    chk("clr_done1", {31'b0, busy1}, 0);
    for (int a = 0; a < 8; a++) begin
      rd_add = 3'(a);
      tick();
      chk("clr_rd", {29'b0, dout0}, 0);
      chk("b2b_rv", {31'b0, rv0}, 1);
    end
    rd_en = 1'b0;
    wr_en = 1'b1; wr_add = 3'd2; data_in = 3'b101;
    tick();
    chk("wr_no_rv", {31'b0, rv0}, 0);
    wr_en = 1'b0; rd_en = 1'b1; rd_add = 3'd2;
    tick();
    chk("rd2_data", {29'b0, dout0}, 5);
    chk("rd2_rv", {31'b0, rv0}, 1);
    chk("rd2_coll", {31'b0, coll0}, 0);
    rd_en = 1'b0;
    tick();
    chk("hold_data", {29'b0, dout0}, 5);
    chk("hold_rv", {31'b0, rv0}, 0);
    wr_en = 1'b1; wr_add = 3'd6; data_in = 3'b011; rd_en = 1'b1; rd_add = 3'd2;
    tick();
    chk("indep_data", {29'b0, dout0}, 5);
    chk("indep_coll", {31'b0, coll0}, 0);
    wr_en = 1'b0; rd_add = 3'd6;
    tick();
    chk("indep_rd6", {29'b0, dout0}, 3);
    rd_en = 1'b0; wr_en = 1'b1; wr_add = 3'd4; data_in = 3'b001;
    tick();
    rd_en = 1'b1; rd_add = 3'd4; data_in = 3'b110;
    tick();
    chk("coll_wf_data", {29'b0, dout0}, 6);
    chk("coll_wf_flag", {31'b0, coll0}, 1);
    chk("coll_rf_data", {29'b0, dout1}, 1);
    chk("coll_rf_flag", {31'b0, coll1}, 1);
    wr_en = 1'b0;
    tick();
    chk("after_coll0", {29'b0, dout0}, 6);
    chk("after_coll1", {29'b0, dout1}, 6);
    chk("coll_pulse", {31'b0, coll1}, 0);
    rst = 1'b1; rd_en = 1'b1; rd_add = 3'd4; wr_en = 1'b1; wr_add = 3'd5; data_in = 3'b111;
    tick();
    chk("abort_rv", {31'b0, rv0}, 0);
    chk("abort_dout", {29'b0, dout0}, 0);
    chk("abort_busy", {31'b0, busy0}, 1);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", {31'b0, busy0}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b1; wr_add = 3'd0; data_in = 3'b111; rd_en = 1'b1; rd_add = 3'd0;
    for (int i = 0; i < 8; i++) begin
      chk("re_busy", {31'b0, busy0}, 1);
      tick();
      chk("re_rv", {31'b0, rv0}, 0);
    end
    chk("re_done", {31'b0, busy0}, 0);
    wr_add = 3'd1; data_in = 3'b011;
    tick();
    chk("first_rd0", {29'b0, dout0}, 0);
    chk("first_rv", {31'b0, rv0}, 1);
    wr_en = 1'b0; rd_add = 3'd1;
    tick();
    chk("first_wr", {29'b0, dout0}, 3);
    rd_en = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
